debouncer: RTL and testbench



---
 rtl/debouncer.sv | 81 ++++++++
 tb/tb_debouncer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
`timescale 1ns/10ps
// debouncer: cleans a raw, asynchronous push-button level.
// The input is synchronized through SYNC_STAGES flops, then filtered by a
// stability counter. btn_state changes only after the synchronized input has
// differed from it for STABLE_CYCLES consecutive clocks. btn_pressed pulses
// for one cycle when a 0->1 change of btn_state is accepted.
// Optional build macro DEBOUNCER_RELEASE_PULSE_EN adds btn_released, a
// one-cycle pulse when a 1->0 change of btn_state is accepted.
module debouncer #(
   parameter int STABLE_CYCLES = 50000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_state,
   output logic btn_pressed
`ifdef DEBOUNCER_RELEASE_PULSE_EN
   ,
   output logic btn_released
`endif
);

   // A 1-cycle filter still needs one counter bit to hold the compare value.
   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CNT_W-1:0]       cnt;
   logic                   differs;
   logic                   accept;

   // Shift the raw level through the synchronizer chain; bit 0 sees btn_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign sync    = sync_q[SYNC_STAGES-1];
   assign differs = (sync != btn_state);
   // The counter only reaches CNT_LAST after that many consecutive differing
   // cycles, because any agreeing cycle clears it.
   assign accept  = differs && (cnt == CNT_LAST);

   // Stability filter: count differing cycles, accept the new level on the
   // last one, and restart from zero whenever the input agrees again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         btn_state   <= 1'b0;
         btn_pressed <= 1'b0;
      end else if (!differs) begin
         cnt         <= '0;
         btn_pressed <= 1'b0;
      end else if (accept) begin
         cnt         <= '0;
         btn_state   <= sync;
         btn_pressed <= sync;
      end else begin
         cnt         <= cnt + CNT_W'(1);
         btn_pressed <= 1'b0;
      end
   end

`ifdef DEBOUNCER_RELEASE_PULSE_EN
   // Release pulse: registered alongside btn_state so it lines up with the
   // first cycle btn_state reads 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_released <= 1'b0;
      end else begin
         btn_released <= accept && !sync;
      end
   end
`endif

endmodule

// File: tb/tb_debouncer.sv
`timescale 1ns/10ps
// tb_debouncer: three debouncer instances (default, 8-cycle, 4-cycle filter)
// share clk/rst. Expected pulses are queued as {kind, instance, cycle} when
// stimulus is driven and compared in order as the DUTs emit them.
module tb_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] st;
  logic [2:0] pr;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  logic [2:0] rl;
`endif

  int cyc    = 0;
  int n_test = 0;
  int n_fail = 0;
  int t0;

  // entry: {kind[1:0] (1=press, 2=release), inst[1:0], cycle[31:0]}
  logic [35:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #0.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  debouncer u_dut_def (
    .clk(clk), .rst(rst), .btn_in(btn[0]), .btn_state(st[0]), .btn_pressed(pr[0])
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    , .btn_released(rl[0])
`endif
  );

  debouncer #(.STABLE_CYCLES(8)) u_dut_8 (
    .clk(clk), .rst(rst), .btn_in(btn[1]), .btn_state(st[1]), .btn_pressed(pr[1])
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    , .btn_released(rl[1])
`endif
  );

  debouncer #(.STABLE_CYCLES(4)) u_dut_4 (
    .clk(clk), .rst(rst), .btn_in(btn[2]), .btn_state(st[2]), .btn_pressed(pr[2])
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    , .btn_released(rl[2])
`endif
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void expect_pulse(input logic [1:0] kind, input logic [1:0] inst, input int at);
    exp_q.push_back({kind, inst, 32'(at)});
  endfunction

  task automatic score(input logic [35:0] obs);
    if (exp_q.size() == 0) check("pulse_unexpected", obs, 36'd0);
    else                   check("pulse", obs, exp_q.pop_front());
  endtask

  // scoreboard monitor: every observed pulse must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (pr[i]) score({2'd1, 2'(i), 32'(cyc)});
`ifdef DEBOUNCER_RELEASE_PULSE_EN
        if (rl[i]) score({2'd2, 2'(i), 32'(cyc)});
`endif
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int inst, input logic val, input int hold);
    btn[inst] = val;
    repeat (hold) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    btn = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 36'(st), 36'd0);
    check("rst_pressed", 36'(pr), 36'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // clean press on the default-parameter instance
    t0 = cyc;
    btn[0] = 1'b1;
    expect_pulse(2'd1, 2'd0, t0 + 50002);
    wait_until(t0 + 50001);
    check("def_state_before", 36'(st[0]), 36'd0);
    @(negedge clk);
    check("def_state_accept", 36'(st[0]), 36'd1);
    wait_until(t0 + 65536);
    check("def_state_held", 36'(st[0]), 36'd1);
    btn[0] = 1'b0;

    // bounce rejection, STABLE_CYCLES=8
    drive(1, 1'b1, 3); drive(1, 1'b0, 1);
    drive(1, 1'b1, 5); drive(1, 1'b0, 1);
    drive(1, 1'b1, 7); drive(1, 1'b0, 1);
    check("b8_bounce_state", 36'(st[1]), 36'd0);
    t0 = cyc;
    btn[1] = 1'b1;
    expect_pulse(2'd1, 2'd1, t0 + 10);
    wait_until(t0 + 9);
    check("b8_state_before", 36'(st[1]), 36'd0);
    @(negedge clk);
    check("b8_state_accept", 36'(st[1]), 36'd1);
    // held button: one pulse only over 1000 cycles
    wait_until(t0 + 1000);
    check("b8_state_held", 36'(st[1]), 36'd1);

    // release, STABLE_CYCLES=8
    t0 = cyc;
    btn[1] = 1'b0;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    expect_pulse(2'd2, 2'd1, t0 + 10);
`endif
    wait_until(t0 + 9);
    check("b8_rel_before", 36'(st[1]), 36'd1);
    @(negedge clk);
    check("b8_rel_accept", 36'(st[1]), 36'd0);
    wait_until(t0 + 12);
    check("b8_rel_after", 36'(st[1]), 36'd0);

    // release glitch, STABLE_CYCLES=4
    t0 = cyc;
    btn[2] = 1'b1;
    expect_pulse(2'd1, 2'd2, t0 + 6);
    wait_until(t0 + 20);
    check("b4_pressed_state", 36'(st[2]), 36'd1);
    drive(2, 1'b0, 3);
    btn[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b4_glitch_state", 36'(st[2]), 36'd1);
    end
    t0 = cyc;
    btn[2] = 1'b0;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    expect_pulse(2'd2, 2'd2, t0 + 6);
`endif
    wait_until(t0 + 10);
    check("b4_released_state", 36'(st[2]), 36'd0);

    // asynchronous reset mid-cycle with the button held
    t0 = cyc;
    btn[1] = 1'b1;
    expect_pulse(2'd1, 2'd1, t0 + 10);
    wait_until(t0 + 20);
    check("rst_pre_state", 36'(st), 36'b011);
    @(posedge clk);
    #0.25 rst = 1'b1;
    #0.1;
    check("rst_async_state", 36'(st), 36'd0);
    check("rst_async_pressed", 36'(pr), 36'd0);
    repeat (3) @(negedge clk);
    check("rst_hold_state", 36'(st), 36'd0);
    t0 = cyc;
    rst = 1'b0;
    expect_pulse(2'd1, 2'd1, t0 + 10);
    wait_until(t0 + 9);
    check("rst_requal_before", 36'(st[1]), 36'd0);
    @(negedge clk);
    check("rst_requal_accept", 36'(st[1]), 36'd1);
    wait_until(t0 + 20);
    check("queue_empty", 36'(exp_q.size()), 36'd0);

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
